// File: rtl/fe65p2_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fe65p2_scan_pkg
// Purpose : Shared widths, drain quiet constant and sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package fe65p2_scan_pkg;

    localparam int STEP_W_DEF  = 8;
    localparam int CNT_W_DEF   = 16;
    localparam int PER_W_DEF   = 16;
    localparam int DRAIN_QUIET = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_SPI = 3'd2,
        S_INJ      = 3'd3,
        S_GAP      = 3'd4,
        S_DRAIN    = 3'd5,
        S_NEXT     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fe65p2_scan_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : fe65p2_scan_seq_if
// Purpose : Control/status bundle between the host side and the scan sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface fe65p2_scan_seq_if
    import fe65p2_scan_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PER_W  = PER_W_DEF
);
    logic              START;
    logic              ABORT;
    logic [STEP_W-1:0] MASK_STEPS;
    logic [CNT_W-1:0]  INJ_COUNT;
    logic [PER_W-1:0]  INJ_PERIOD;
    logic              SPI_DONE;
    logic              FIFO_EMPTY;
    logic              SPI_START;
    logic              INJ_START;
    logic              BUSY;
    logic              DONE;
    logic [STEP_W-1:0] STEP;

    modport master (
        output START, ABORT, MASK_STEPS, INJ_COUNT, INJ_PERIOD, SPI_DONE, FIFO_EMPTY,
        input  SPI_START, INJ_START, BUSY, DONE, STEP
    );

    modport slave (
        input  START, ABORT, MASK_STEPS, INJ_COUNT, INJ_PERIOD, SPI_DONE, FIFO_EMPTY,
        output SPI_START, INJ_START, BUSY, DONE, STEP
    );
endinterface
`default_nettype wire

// File: rtl/fe65p2_scan_timer.sv
`default_nettype none
// ============================================================================
// Module  : fe65p2_scan_timer
// Purpose : Loadable down-counter; load wins over tick, stops at zero.
// Revision: 1.0 - initial release
// ============================================================================
module fe65p2_scan_timer #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] value,
    input  wire logic             tick,
    output logic                  expired
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);
endmodule
`default_nettype wire

// File: rtl/fe65p2_scan_seq.sv
`default_nettype none
// ============================================================================
// Module  : fe65p2_scan_seq
// Purpose : Mask-step scan sequencer (SPI load, then timed inject pulses).
//           SCAN_SEQ_FIFO_DRAIN_EN adds a FIFO-quiet wait between steps.
// Revision: 1.0 - initial release
// ============================================================================
module fe65p2_scan_seq
    import fe65p2_scan_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PER_W  = PER_W_DEF
) (
    input  wire logic        BUS_CLK,
    input  wire logic        BUS_RST_N,
    fe65p2_scan_seq_if.slave bus
);
`ifdef SCAN_SEQ_FIFO_DRAIN_EN
    localparam state_t S_POST_INJ = S_DRAIN;
`else
    localparam state_t S_POST_INJ = S_NEXT;
    logic unused_fifo_empty;
    assign unused_fifo_empty = bus.FIFO_EMPTY;
`endif

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d, mask_q, mask_d;
    logic [CNT_W-1:0]  count_q, count_d, inj_cnt_q, inj_cnt_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              spi_start_q, spi_start_d, inj_start_q, inj_start_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              tmr_load, tmr_tick, tmr_expired;
    logic [PER_W-1:0]  tmr_value;

    // period_q holds the effective period (never 0); GAP lasts period-1 cycles
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        mask_d    = mask_q;
        count_d   = count_q;
        period_d  = period_q;
        inj_cnt_d = inj_cnt_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_tick  = 1'b0;
        tmr_value = period_q - PER_W'(2);

        if (bus.ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        mask_d   = bus.MASK_STEPS;
                        count_d  = bus.INJ_COUNT;
                        period_d = (bus.INJ_PERIOD == '0) ? PER_W'(1) : bus.INJ_PERIOD;
                        if (bus.MASK_STEPS == '0) begin
                            done_d = 1'b1;
                        end else begin
                            step_d    = '0;
                            inj_cnt_d = '0;
                            state_d   = S_LOAD;
                        end
                    end
                end
                S_LOAD:     state_d = S_WAIT_SPI;
                S_WAIT_SPI: begin
                    if (bus.SPI_DONE) begin
                        state_d = (count_q != '0) ? S_INJ : S_POST_INJ;
                    end
                end
                S_INJ: begin
                    inj_cnt_d = inj_cnt_q + CNT_W'(1);
                    if (period_q > PER_W'(1)) begin
                        tmr_load = 1'b1;
                        state_d  = S_GAP;
                    end else begin
                        state_d = (inj_cnt_d == count_q) ? S_POST_INJ : S_INJ;
                    end
                end
                S_GAP: begin
                    if (tmr_expired) begin
                        state_d = (inj_cnt_q == count_q) ? S_POST_INJ : S_INJ;
                    end else begin
                        tmr_tick = 1'b1;
                    end
                end
                S_DRAIN: begin
`ifdef SCAN_SEQ_FIFO_DRAIN_EN
                    if (!bus.FIFO_EMPTY) begin
                        tmr_load  = 1'b1;
                        tmr_value = PER_W'(DRAIN_QUIET - 1);
                    end else if (tmr_expired) begin
                        state_d = S_NEXT;
                    end else begin
                        tmr_tick = 1'b1;
                    end
`else
                    state_d = S_NEXT;
`endif
                end
                S_NEXT: begin
                    if (step_q == mask_q - STEP_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        step_d    = step_q + STEP_W'(1);
                        inj_cnt_d = '0;
                        state_d   = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef SCAN_SEQ_FIFO_DRAIN_EN
        if ((state_d == S_DRAIN) && (state_q != S_DRAIN)) begin
            tmr_load  = 1'b1;
            tmr_value = PER_W'(DRAIN_QUIET - 1);
        end
`endif

        // Pulses are registered with the state they belong to
        spi_start_d = (state_d == S_LOAD);
        inj_start_d = (state_d == S_INJ);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            mask_q      <= '0;
            count_q     <= '0;
            period_q    <= '0;
            inj_cnt_q   <= '0;
            spi_start_q <= 1'b0;
            inj_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            period_q    <= period_d;
            inj_cnt_q   <= inj_cnt_d;
            spi_start_q <= spi_start_d;
            inj_start_q <= inj_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    fe65p2_scan_timer #(
        .WIDTH (PER_W)
    ) u_timer (
        .clk     (BUS_CLK),
        .rst_n   (BUS_RST_N),
        .load    (tmr_load),
        .value   (tmr_value),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    assign bus.SPI_START = spi_start_q;
    assign bus.INJ_START = inj_start_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.STEP      = step_q;
endmodule
`default_nettype wire

// File: tb/tb_fe65p2_scan_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_fe65p2_scan_seq
// Purpose : Self-checking bench; expected timelines come from a cycle-arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fe65p2_scan_seq;
    import fe65p2_scan_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fe65p2_scan_seq_if bus ();

    fe65p2_scan_seq dut (
        .BUS_CLK   (clk),
        .BUS_RST_N (rst_n),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int model_step = 0;
    int fifo_low_until = 0;
    int fifo_drop = -1;

    int e_spi[$], e_spi_step[$], e_inj[$], e_inj_step[$];
    int a_spi[$], a_spi_step[$], a_inj[$], a_inj_step[$], a_done[$];
    int e_done;
    int a_busy;
    int a_final_step;

    typedef struct {
        int mask; int cnt; int per; int d;
        int exp_spi; int exp_inj; int exp_done; int exp_step;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit fifo_at(input int rel);
        return (rel >= fifo_low_until) && (rel != fifo_drop);
    endfunction

    // Timeline relative to the START cycle (rel 0): SPI_START at s, SPI_DONE at s+d,
    // injections every P cycles from s+d+1, next step's SPI_START right after
    // the step's last slot (plus the FIFO-quiet wait when draining).
    task automatic model(input int mask, input int cnt, input int per, input int d);
        int p, s, n;
`ifdef SCAN_SEQ_FIFO_DRAIN_EN
        int t, run;
`endif
        p = (per == 0) ? 1 : per;
        e_spi.delete(); e_spi_step.delete(); e_inj.delete(); e_inj_step.delete();
        s = 1;
        for (int i = 0; i < mask; i++) begin
            e_spi.push_back(s);
            e_spi_step.push_back(i);
            for (int j = 0; j < cnt; j++) begin
                e_inj.push_back(s + d + 1 + j * p);
                e_inj_step.push_back(i);
            end
            n = s + d + 1 + cnt * p;
`ifdef SCAN_SEQ_FIFO_DRAIN_EN
            run = 0;
            t = n;
            while (run < DRAIN_QUIET && t < n + 4000) begin
                run = fifo_at(t) ? run + 1 : 0;
                t++;
            end
            n = t;
`endif
            s = n + 1;
        end
        e_done = (mask == 0) ? 1 : s;
    endtask

    task automatic run_scan(input int mask, input int cnt, input int per, input int d,
                            input int abort_rel, input int start2_rel,
                            input int rst_rel, input int exp_step_pre);
        int spi_due[$];
        int stop, limit, exp_done_n, exp_busy;
        bit finished;
        a_spi.delete(); a_spi_step.delete(); a_inj.delete(); a_inj_step.delete(); a_done.delete();
        a_busy = 0;
        model(mask, cnt, per, d);
        limit = e_done + 40;
        stop = -1;
        finished = 1'b0;
        bus.MASK_STEPS = 8'(mask);
        bus.INJ_COUNT  = 16'(cnt);
        bus.INJ_PERIOD = 16'(per);
        for (int rel = 0; rel <= limit; rel++) begin
            if (rel > 0) begin
                if (bus.SPI_START) begin
                    a_spi.push_back(rel); a_spi_step.push_back(int'(bus.STEP));
                    spi_due.push_back(rel + d);
                end
                if (bus.INJ_START) begin
                    a_inj.push_back(rel); a_inj_step.push_back(int'(bus.STEP));
                end
                if (bus.DONE) a_done.push_back(rel);
                if (bus.BUSY) a_busy++;
                a_final_step = int'(bus.STEP);
            end
            if (rel == rst_rel) begin
                check("pre_reset_busy", bus.BUSY, 1);
                check("pre_reset_step", bus.STEP, exp_step_pre);
                #2 rst_n = 1'b0;
                #1;
                check("rst_spi_start", bus.SPI_START, 0);
                check("rst_inj_start", bus.INJ_START, 0);
                check("rst_busy", bus.BUSY, 0);
                check("rst_done", bus.DONE, 0);
                check("rst_step", bus.STEP, 0);
                bus.START = 1'b0; bus.ABORT = 1'b0; bus.SPI_DONE = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                model_step = 0;
                return;
            end
            if (stop < 0 && rel > 0 && !bus.BUSY) stop = rel + 4;
            if (rel == stop) begin
                finished = 1'b1;
                break;
            end
            bus.START = (rel == 0) || (rel == start2_rel);
            bus.ABORT = (rel == abort_rel);
            bus.SPI_DONE = 1'b0;
            if (spi_due.size() > 0 && spi_due[0] == rel) begin
                bus.SPI_DONE = 1'b1;
                void'(spi_due.pop_front());
            end
            bus.FIFO_EMPTY = fifo_at(rel);
            @(negedge clk);
        end
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.SPI_DONE = 1'b0;
        check("scan_ended_in_budget", finished, 1);

        if (abort_rel >= 0) begin
            while (e_spi.size() > 0 && e_spi[$] > abort_rel) begin
                void'(e_spi.pop_back()); void'(e_spi_step.pop_back());
            end
            while (e_inj.size() > 0 && e_inj[$] > abort_rel) begin
                void'(e_inj.pop_back()); void'(e_inj_step.pop_back());
            end
            exp_done_n = 0;
            exp_busy = abort_rel;
            if (e_spi.size() > 0) model_step = e_spi.size() - 1;
        end else begin
            exp_done_n = 1;
            exp_busy = e_done - 1;
            if (mask > 0) model_step = mask - 1;
        end

        check("spi_start_count", a_spi.size(), e_spi.size());
        for (int i = 0; i < e_spi.size() && i < a_spi.size(); i++) begin
            check("spi_start_cycle", a_spi[i], e_spi[i]);
            check("spi_start_step", a_spi_step[i], e_spi_step[i]);
        end
        check("inj_start_count", a_inj.size(), e_inj.size());
        for (int i = 0; i < e_inj.size() && i < a_inj.size(); i++) begin
            check("inj_start_cycle", a_inj[i], e_inj[i]);
            check("inj_start_step", a_inj_step[i], e_inj_step[i]);
        end
        check("done_count", a_done.size(), exp_done_n);
        if (exp_done_n == 1 && a_done.size() > 0) check("done_cycle", a_done[0], e_done);
        check("busy_cycles", a_busy, exp_busy);
        check("final_step", a_final_step, model_step);
    endtask

    initial begin
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.SPI_DONE = 1'b0; bus.FIFO_EMPTY = 1'b1;
        bus.MASK_STEPS = '0; bus.INJ_COUNT = '0; bus.INJ_PERIOD = '0;

        vt[0] = '{2, 3, 5, 10, 2, 6, 55, 1};
        vt[1] = '{0, 3, 5, 10, 0, 0, 1, 1};
        vt[2] = '{3, 0, 5, 4, 3, 0, 19, 2};
        vt[3] = '{1, 4, 0, 3, 1, 4, 10, 0};
        vt[4] = '{1, 2, 1, 2, 1, 2, 7, 0};
        vt[5] = '{2, 1, 2, 1, 2, 2, 11, 1};

        repeat (3) @(negedge clk);
        check("reset_spi_start", bus.SPI_START, 0);
        check("reset_inj_start", bus.INJ_START, 0);
        check("reset_busy", bus.BUSY, 0);
        check("reset_done", bus.DONE, 0);
        check("reset_step", bus.STEP, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fifo_low_until = 0;
        fifo_drop = -1;
        for (int k = 0; k < 6; k++) begin
            int exp_done;
            exp_done = vt[k].exp_done;
`ifdef SCAN_SEQ_FIFO_DRAIN_EN
            exp_done = exp_done + DRAIN_QUIET * vt[k].mask;
`endif
            run_scan(vt[k].mask, vt[k].cnt, vt[k].per, vt[k].d, -1, -1, -1, 0);
            check("vec_spi_pulses", a_spi.size(), vt[k].exp_spi);
            check("vec_inj_pulses", a_inj.size(), vt[k].exp_inj);
            check("vec_done_pulses", a_done.size(), 1);
            if (a_done.size() > 0) check("vec_done_cycle", a_done[0], exp_done);
            check("vec_final_step", a_final_step, vt[k].exp_step);
        end

        // Abort mid-GAP of step 0, then a fresh scan must restart at STEP 0
        run_scan(2, 3, 5, 10, 20, -1, -1, 0);
        check("abort_step_held", a_final_step, 0);
        run_scan(2, 1, 1, 1, -1, -1, -1, 0);
        // START together with ABORT in IDLE is dropped
        run_scan(1, 1, 1, 1, 0, -1, -1, 0);
        // Second START while busy is ignored
        run_scan(1, 3, 0, 2, -1, 3, -1, 0);

        // SPI_DONE while idle must not start injection
        bus.SPI_DONE = 1'b1;
        @(negedge clk);
        bus.SPI_DONE = 1'b0;
        check("idle_spi_done_inj", bus.INJ_START, 0);
        check("idle_spi_done_busy", bus.BUSY, 0);
        @(negedge clk);

`ifdef SCAN_SEQ_FIFO_DRAIN_EN
        fifo_low_until = 47;
        fifo_drop = 57;
        run_scan(1, 2, 3, 2, -1, -1, -1, 0);
        if (a_done.size() > 0) check("drain_done_cycle", a_done[0], 75);
        fifo_low_until = 100000;
        fifo_drop = -1;
        run_scan(2, 1, 20, 1, -1, -1, 30, 0);
`else
        run_scan(2, 1, 20, 1, -1, -1, 30, 1);
`endif
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            int m, c, p, d, ab, s2;
            m = $urandom_range(0, 3);
            c = $urandom_range(0, 4);
            p = $urandom_range(0, 4);
            d = $urandom_range(1, 6);
            fifo_low_until = $urandom_range(0, 30);
            fifo_drop = $urandom_range(0, 60);
            model(m, c, p, d);
            ab = -1;
            s2 = -1;
            if (e_done >= 3 && $urandom_range(0, 4) == 0) ab = $urandom_range(1, e_done - 1);
            else if (e_done >= 3 && $urandom_range(0, 2) == 0) s2 = $urandom_range(1, e_done - 1);
            run_scan(m, c, p, d, ab, s2, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
